calc_stack_ctrl: RTL and testbench
==================================

Name: calc_stack_ctrl

Overview:
- Command sequencer and storage for the calculator's operand stack.
- Accepts keypad/decoder commands over a valid/ready handshake, executes stack and arithmetic operations (multi-cycle multiply), and flags errors.
- Publishes a frame-synchronous, tear-free snapshot of the stack as the packed digit vector and occupancy mask consumed by picture_generator.
- Sits between input decoding and the VGA picture path, replacing the constant digit vector.

Parameters:
- DEPTH, 15, number of stack entries; equals the digit slots on screen.
- DATA_W, 4, bits per entry; one hex glyph per entry.

Ports:
- clk  input  1  pixel-domain clock (25 MHz PLL output).
- reset  input  1  asynchronous, active-high; clears all state.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE; a command is accepted on a clk edge with cmd_valid&cmd_ready.
- cmd_op  input  3  opcode (calc_pkg::op_t).
- cmd_data  input  DATA_W  operand for PUSH; ignored otherwise.
- frame_start  input  1  one-cycle pulse at start of vertical blank; triggers snapshot.
- numbers  output  DEPTH*DATA_W  snapshot; slice [i*DATA_W +: DATA_W] = entry i below top (i=0 is TOS).
- occupied  output  DEPTH  snapshot mask; bit i set iff i < depth count.
- depth  output  4  live entry count, 0..DEPTH.
- err  output  1  one-cycle pulse when a command is rejected.
- busy  output  1  inverse of cmd_ready.

Behaviour:
- Reset values:
  - numbers=0, occupied=0, depth=0, err=0, cmd_ready=1, busy=0.
  - Storage cleared; FSM in IDLE.
- Opcodes:
  - PUSH=0, POP=1, ADD=2, SUB=3, MUL=4, DUP=5, SWAP=6, CLEAR=7.
- FSM states: IDLE, DECODE, MUL_ITER.
  - IDLE: on accept at edge T, latch op/data and go to DECODE.
  - DECODE (cycle after T): check legality.
    - Illegal: at edge T+1, pulse err (high during cycle T+1..T+2), leave stack unchanged, return to IDLE.
    - Legal non-MUL: commit at edge T+1, return to IDLE. cmd_ready is high again in the cycle after T+1, so peak throughput is one command per 2 cycles.
    - Legal MUL: load multiplicand/multiplier, clear accumulator, go to MUL_ITER.
  - MUL_ITER: shift-add, one multiplier bit per cycle, for exactly DATA_W cycles.
    - Commit on the edge that ends the last iteration, at T+1+DATA_W; then IDLE.
- Legality:
  - PUSH: requires depth<DEPTH.
  - DUP: requires 1<=depth<DEPTH.
  - POP: requires depth>=1.
  - ADD/SUB/MUL/SWAP: require depth>=2.
  - CLEAR: always legal.
- Semantics (TOS=top, NOS=second):
  - ADD: pops 2, pushes (NOS+TOS) mod 2^DATA_W.
  - SUB: pushes (NOS-TOS) mod 2^DATA_W.
  - MUL: pushes low DATA_W bits of NOS*TOS.
  - Net depth change: -1 for binary ops; SWAP 0; DUP +1; CLEAR sets depth=0 and zeroes entries.
  - No carry or overflow flag; wrap is silent.
  - Vacated entries are written 0.
- Commits are atomic: the stack and depth change on a single edge.
- Snapshot:
  - On a clk edge with frame_start=1, numbers/occupied load the committed stack as it stands before that edge.
  - A commit on the same edge is not visible until the next frame_start.
  - Outside frame_start, numbers/occupied hold.
- Handshake:
  - cmd_op/cmd_data are sampled only at accept.
  - cmd_valid while busy is ignored, and the requester must hold it.
  - No queuing.
- Reset asserted mid-operation (including during MUL_ITER): immediate abort, all outputs to reset values, no partial commit.

Decomposition:
- calc_pkg holds:
  - op_t (3-bit opcode enum).
  - state_t (IDLE/DECODE/MUL_ITER).
  - Constants DEPTH_DEF=15 and DATA_W_DEF=4.
- One sub-module, calc_mul_seq:
  - Iterative shift-add multiplier with start/done.
  - Operands DATA_W, result truncated to DATA_W.
  - Same clk and reset.
- Stack storage and FSM stay in calc_stack_ctrl.

Test Plan:
- Reset, then PUSH 3, PUSH 5, ADD, then frame_start: depth=1, numbers[3:0]=8, occupied=15'h0001, err never pulsed, cmd_ready low exactly 1 cycle per command.
- PUSH 7, PUSH 9, SUB: TOS=4'hE (7-9 mod 16); then PUSH 6, MUL: TOS=4'h4 (0xE*6=84, low nibble); MUL busy for 1+4 cycles after accept.
- 15×PUSH 1 then PUSH 2: 16th command pulses err, depth=15, TOS still 1; then DUP: err again.
- From empty: POP, then ADD with depth=1: err pulse each time, stack unchanged. CLEAR from depth 5: depth=0, occupied=0 after next frame_start.
- Commit edge coincident with frame_start: snapshot shows pre-commit stack; next frame_start shows new TOS.
- Assert reset during MUL_ITER cycle 2: depth=0, numbers=0, cmd_ready=1 immediately, no err pulse; a subsequent PUSH A works normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator operand-stack controller.
package calc_pkg;

  localparam int DEPTH_DEF  = 15;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_POP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_MUL   = 3'd4,
    OP_DUP   = 3'd5,
    OP_SWAP  = 3'd6,
    OP_CLEAR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    MUL_ITER = 2'd2
  } state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, product truncated to DATA_W.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_next;

  // Product is taken from the adder so the caller can commit on the final iteration edge.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = (cnt_q == CNT_ONE);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= mcand;
      mplier_q <= mplier;
      acc_q    <= '0;
      cnt_q    <= CNT_INIT;
    end else if (cnt_q != '0) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/calc_stack_ctrl.sv
// Operand-stack command sequencer with frame-synchronous snapshot for the picture generator.
//   state    | meaning
//   IDLE     | ready for a command
//   DECODE   | legality check, commit or reject, or launch multiply
//   MUL_ITER | shift-add multiply running, commit on last iteration
module calc_stack_ctrl
  import calc_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [DATA_W-1:0]       cmd_data,
  input  logic                    frame_start,
  output logic [DEPTH*DATA_W-1:0] numbers,
  output logic [DEPTH-1:0]        occupied,
  output logic [3:0]              depth,
  output logic                    err,
  output logic                    busy
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_t                  state_q, state_d;
  op_t                     op_q;
  logic [DATA_W-1:0]       data_q;
  logic [DATA_W-1:0]       stk_q [DEPTH];
  logic [DATA_W-1:0]       stk_d [DEPTH];
  logic [3:0]              depth_q, depth_d;
  logic                    err_q;
  logic [DEPTH*DATA_W-1:0] numbers_q, numbers_c;
  logic [DEPTH-1:0]        occupied_q, occupied_c;

  logic                    legal, commit, reject, mul_start, mul_done;
  logic [DATA_W-1:0]       mul_product, alu_res;

  calc_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .mcand   (stk_q[1]),
    .mplier  (stk_q[0]),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    legal = 1'b0;
    case (op_q)
      OP_PUSH:                        legal = (depth_q < DEPTH_L);
      OP_DUP:                         legal = (depth_q != 4'd0) && (depth_q < DEPTH_L);
      OP_POP:                         legal = (depth_q != 4'd0);
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: legal = (depth_q >= 4'd2);
      OP_CLEAR:                       legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mul_start = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = DECODE;
      end
      DECODE: begin
        if (!legal) begin
          reject  = 1'b1;
          state_d = IDLE;
        end else if (op_q == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = MUL_ITER;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      MUL_ITER: begin
        if (mul_done) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = stk_q[1] + stk_q[0];
      OP_SUB:  alu_res = stk_q[1] - stk_q[0];
      OP_MUL:  alu_res = mul_product;
      default: alu_res = '0;
    endcase
  end

  // Entries at or beyond depth are kept at zero, so shifts never need masking.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stk_d[i] = stk_q[i];
    depth_d = depth_q;
    case (op_q)
      OP_PUSH, OP_DUP: begin
        stk_d[0] = (op_q == OP_PUSH) ? data_q : stk_q[0];
        for (int i = 1; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
        depth_d = depth_q + 4'd1;
      end
      OP_POP: begin
        for (int i = 0; i < DEPTH-1; i++) stk_d[i] = stk_q[i+1];
        stk_d[DEPTH-1] = '0;
        depth_d = depth_q - 4'd1;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        stk_d[0] = alu_res;
        for (int i = 1; i < DEPTH-1; i++) stk_d[i] = stk_q[i+1];
        stk_d[DEPTH-1] = '0;
        depth_d = depth_q - 4'd1;
      end
      OP_SWAP: begin
        stk_d[0] = stk_q[1];
        stk_d[1] = stk_q[0];
      end
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) stk_d[i] = '0;
        depth_d = 4'd0;
      end
      default: depth_d = depth_q;
    endcase
  end

  always_comb begin
    numbers_c  = '0;
    occupied_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      numbers_c[i*DATA_W +: DATA_W] = stk_q[i];
      occupied_c[i]                 = (4'(i) < depth_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_PUSH;
      data_q     <= '0;
      stk_q      <= '{default: '0};
      depth_q    <= 4'd0;
      err_q      <= 1'b0;
      numbers_q  <= '0;
      occupied_q <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        op_q   <= op_t'(cmd_op);
        data_q <= cmd_data;
      end
      if (commit) begin
        stk_q   <= stk_d;
        depth_q <= depth_d;
      end
      err_q <= reject;
      // Snapshot uses pre-edge stack; a coincident commit shows on the next frame.
      if (frame_start) begin
        numbers_q  <= numbers_c;
        occupied_q <= occupied_c;
      end
    end
  end

  assign numbers  = numbers_q;
  assign occupied = occupied_q;
  assign depth    = depth_q;
  assign err      = err_q;
  assign busy     = ~cmd_ready;

endmodule

// File: tb/tb_calc_stack_ctrl.sv
// Directed bench for calc_stack_ctrl: stack ops, legality, multiply timing, snapshot and reset abort.
module tb_calc_stack_ctrl;

  localparam logic [2:0] P_PUSH = 3'd0, P_POP = 3'd1, P_ADD = 3'd2, P_SUB = 3'd3,
                         P_MUL = 3'd4, P_DUP = 3'd5, P_SWAP = 3'd6, P_CLEAR = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [3:0]  cmd_data = 4'd0;
  logic        frame_start = 1'b0;
  logic        cmd_ready, err, busy;
  logic [59:0] numbers;
  logic [14:0] occupied;
  logic [3:0]  depth;

  int n_checks = 0;
  int n_fail   = 0;

  calc_stack_ctrl #(.DEPTH(15), .DATA_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .frame_start (frame_start),
    .numbers     (numbers),
    .occupied    (occupied),
    .depth       (depth),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  // Issue one command; report cycles with cmd_ready low and err pulses seen until ready returns.
  task automatic send(input logic [2:0] op, input logic [3:0] data, output int busy_cyc, output int err_cnt);
    int w;
    busy_cyc = 0; err_cnt = 0; w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (cmd_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1 cmd_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
      if (cmd_ready !== 1'b1) busy_cyc++;
      w++;
    end while (cmd_ready !== 1'b1 && w < 20);
    if (cmd_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_done_wait: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic frame();
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (numbers !== 60'h0) begin n_fail++; $display("FAIL reset_numbers: got %h required 0", numbers); end
    n_checks++; if (occupied !== 15'h0) begin n_fail++; $display("FAIL reset_occupied: got %h required 0", occupied); end
    n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth: got %0d required 0", depth); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready: ready=%b busy=%b required 1/0", cmd_ready, busy); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add();
    logic [2:0] ops [3] = '{P_PUSH, P_PUSH, P_ADD};
    logic [3:0] dat [3] = '{4'h3, 4'h5, 4'h0};
    int b, e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(ops[i], dat[i], b, e);
      n_checks++; if (b != 1 || e != 0) begin n_fail++; $display("FAIL add_cmd%0d_timing: busy=%0d err=%0d required 1/0", i, b, e); end
    end
    n_checks++; if (depth !== 4'd1) begin n_fail++; $display("FAIL add_depth: got %0d required 1", depth); end
    frame();
    n_checks++; if (numbers !== 60'h8) begin n_fail++; $display("FAIL add_numbers: got %h required 8", numbers); end
    n_checks++; if (occupied !== 15'h0001) begin n_fail++; $display("FAIL add_occupied: got %h required 0001", occupied); end
    send(P_PUSH, 4'hF, b, e);
    send(P_ADD, 4'h0, b, e);
    frame();
    n_checks++; if (numbers !== 60'h7) begin n_fail++; $display("FAIL add_wrap: got %h required 7", numbers); end
  endtask

  task automatic test_sub_mul();
    int b, e;
    do_reset();
    send(P_PUSH, 4'h7, b, e);
    send(P_PUSH, 4'h9, b, e);
    send(P_SUB, 4'h0, b, e);
    frame();
    n_checks++; if (numbers !== 60'hE) begin n_fail++; $display("FAIL sub_tos: got %h required e", numbers); end
    send(P_PUSH, 4'h6, b, e);
    send(P_MUL, 4'h0, b, e);
    n_checks++; if (b != 5 || e != 0) begin n_fail++; $display("FAIL mul_timing: busy=%0d err=%0d required 5/0", b, e); end
    n_checks++; if (depth !== 4'd1) begin n_fail++; $display("FAIL mul_depth: got %0d required 1", depth); end
    frame();
    n_checks++; if (numbers !== 60'h4) begin n_fail++; $display("FAIL mul_tos: got %h required 4", numbers); end
  endtask

  task automatic test_full();
    int b, e, esum;
    do_reset();
    esum = 0;
    for (int i = 0; i < 15; i++) begin send(P_PUSH, 4'h1, b, e); esum += e; end
    n_checks++; if (esum != 0 || depth !== 4'd15) begin n_fail++; $display("FAIL full_fill: errs=%0d depth=%0d required 0/15", esum, depth); end
    send(P_PUSH, 4'h2, b, e);
    n_checks++; if (e != 1 || b != 1) begin n_fail++; $display("FAIL full_push_err: err=%0d busy=%0d required 1/1", e, b); end
    n_checks++; if (depth !== 4'd15) begin n_fail++; $display("FAIL full_depth: got %0d required 15", depth); end
    frame();
    n_checks++; if (numbers !== 60'h111111111111111) begin n_fail++; $display("FAIL full_numbers: got %h required 111111111111111", numbers); end
    n_checks++; if (occupied !== 15'h7FFF) begin n_fail++; $display("FAIL full_occupied: got %h required 7fff", occupied); end
    send(P_DUP, 4'h0, b, e);
    n_checks++; if (e != 1 || depth !== 4'd15) begin n_fail++; $display("FAIL full_dup_err: err=%0d depth=%0d required 1/15", e, depth); end
  endtask

  task automatic test_underflow_clear();
    int b, e;
    do_reset();
    send(P_POP, 4'h0, b, e);
    n_checks++; if (e != 1 || depth !== 4'd0) begin n_fail++; $display("FAIL pop_empty: err=%0d depth=%0d required 1/0", e, depth); end
    send(P_PUSH, 4'h4, b, e);
    send(P_ADD, 4'h0, b, e);
    n_checks++; if (e != 1 || depth !== 4'd1) begin n_fail++; $display("FAIL add_one: err=%0d depth=%0d required 1/1", e, depth); end
    frame();
    n_checks++; if (numbers !== 60'h4 || occupied !== 15'h1) begin n_fail++; $display("FAIL add_one_stack: numbers=%h occ=%h required 4/0001", numbers, occupied); end
    for (int i = 1; i <= 4; i++) send(P_PUSH, 4'(i), b, e);
    n_checks++; if (depth !== 4'd5) begin n_fail++; $display("FAIL pre_clear_depth: got %0d required 5", depth); end
    send(P_CLEAR, 4'h0, b, e);
    n_checks++; if (e != 0 || depth !== 4'd0) begin n_fail++; $display("FAIL clear: err=%0d depth=%0d required 0/0", e, depth); end
    frame();
    n_checks++; if (numbers !== 60'h0 || occupied !== 15'h0) begin n_fail++; $display("FAIL clear_snapshot: numbers=%h occ=%h required 0/0", numbers, occupied); end
  endtask

  task automatic test_swap_dup();
    int b, e;
    do_reset();
    send(P_PUSH, 4'h1, b, e);
    send(P_PUSH, 4'h2, b, e);
    send(P_SWAP, 4'h0, b, e);
    send(P_DUP, 4'h0, b, e);
    n_checks++; if (depth !== 4'd3) begin n_fail++; $display("FAIL swap_dup_depth: got %0d required 3", depth); end
    frame();
    n_checks++; if (numbers !== 60'h211 || occupied !== 15'h7) begin n_fail++; $display("FAIL swap_dup_stack: numbers=%h occ=%h required 211/0007", numbers, occupied); end
  endtask

  task automatic test_frame_commit();
    int b, e;
    do_reset();
    send(P_PUSH, 4'hA, b, e);
    frame();
    cmd_valid = 1'b1; cmd_op = P_PUSH; cmd_data = 4'hB;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    n_checks++; if (numbers !== 60'hA || occupied !== 15'h1) begin n_fail++; $display("FAIL coincident_snapshot: numbers=%h occ=%h required a/0001", numbers, occupied); end
    n_checks++; if (depth !== 4'd2) begin n_fail++; $display("FAIL coincident_depth: got %0d required 2", depth); end
    frame();
    n_checks++; if (numbers !== 60'hAB || occupied !== 15'h3) begin n_fail++; $display("FAIL next_snapshot: numbers=%h occ=%h required ab/0003", numbers, occupied); end
  endtask

  task automatic test_reset_mid_mul();
    int b, e;
    do_reset();
    send(P_PUSH, 4'h3, b, e);
    send(P_PUSH, 4'h5, b, e);
    frame();
    n_checks++; if (numbers !== 60'h35) begin n_fail++; $display("FAIL premul_numbers: got %h required 35", numbers); end
    cmd_valid = 1'b1; cmd_op = P_MUL; cmd_data = 4'h0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_iter2: got %b required 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (depth !== 4'd0 || numbers !== 60'h0 || occupied !== 15'h0) begin n_fail++; $display("FAIL abort_state: depth=%0d numbers=%h occ=%h required 0/0/0", depth, numbers, occupied); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: ready=%b busy=%b err=%b required 1/0/0", cmd_ready, busy, err); end
    @(negedge clk); reset = 1'b0;
    send(P_PUSH, 4'hA, b, e);
    n_checks++; if (b != 1 || e != 0 || depth !== 4'd1) begin n_fail++; $display("FAIL post_abort_push: busy=%0d err=%0d depth=%0d required 1/0/1", b, e, depth); end
    frame();
    n_checks++; if (numbers !== 60'hA) begin n_fail++; $display("FAIL post_abort_numbers: got %h required a", numbers); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_full();
    test_underflow_clear();
    test_swap_dup();
    test_frame_commit();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
